mtr_pwm_drv: RTL and testbench

Motor PWM driver for the Knight's Tour drive train. It sits downstream of the PID block and converts the signed 11-bit `lft_spd`/`rght_spd` commands into complementary, non-overlapping high/low-side PWM pairs for the left and right H-bridges. Duty changes are double-buffered so they take effect only at a PWM period boundary. A period-start strobe is exported for synchronous sampling elsewhere, e.g. current sense.

---
 rtl/mtr_pkg.sv | 31 +++
 rtl/pwm11_chan.sv | 74 +++++++
 rtl/mtr_pwm_drv.sv | 87 ++++++++
 tb/tb_mtr_pwm_drv.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
// -----------------------------------------------------------------------------
// mtr_pkg
// Shared constants, types and helpers for the motor PWM driver.
//   PWM_W          : width of the period counter, duty and speed commands
//   PWM_PERIOD     : clocks per PWM period (counter wraps at PWM_PERIOD-1)
//   DUTY_OFFSET    : offset that maps a signed speed onto an unsigned duty
//   NONOVERLAP_DEF : default dead time inserted before either side rises
//   CNT_LAST       : final counter value of a period (duty capture point)
//   spd_t          : signed speed command type
//   spd2duty()     : signed speed -> unsigned duty conversion
// -----------------------------------------------------------------------------
package mtr_pkg;

   localparam int PWM_W      = 11;
   localparam int PWM_PERIOD = 2048;

   localparam logic [PWM_W-1:0] DUTY_OFFSET    = 11'h400;
   localparam logic [PWM_W-1:0] NONOVERLAP_DEF = 11'h020;
   localparam logic [PWM_W-1:0] CNT_LAST       = PWM_W'(PWM_PERIOD - 1);

   typedef logic signed [PWM_W-1:0] spd_t;

   // Adding half scale modulo 2^PWM_W flips the MSB: -1024 -> 0,
   // 0 -> 1024 (50 %), +1023 -> 2047.
   function automatic logic [PWM_W-1:0] spd2duty(input spd_t spd);
      logic [PWM_W-1:0] duty_s;
      duty_s = $unsigned(spd) + DUTY_OFFSET;
      return duty_s;
   endfunction

endpackage

// File: rtl/pwm11_chan.sv
// -----------------------------------------------------------------------------
// pwm11_chan
// One H-bridge channel: double-buffered duty plus complementary,
// non-overlapping high/low-side PWM decode against the shared counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cnt        : shared free-running period counter
//   cap        : high in the last cycle of a period; loads the duty shadow
//   mtr_en     : output enable, low forces both outputs low (coast)
//   spd        : signed speed command (two's complement)
//   PWM1       : high-side drive, registered
//   PWM2       : low-side drive, registered
// -----------------------------------------------------------------------------
module pwm11_chan
   import mtr_pkg::*;
#(
   parameter logic [PWM_W-1:0] NONOVERLAP = NONOVERLAP_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PWM_W-1:0] cnt,
   input  logic             cap,
   input  logic             mtr_en,
   input  logic [PWM_W-1:0] spd,
   output logic             PWM1,
   output logic             PWM2
);

   logic [PWM_W-1:0] duty_r;      // duty in force for the current period
   logic [PWM_W:0]   pwm2_thr_s;  // 12-bit low-side turn-on point
   logic             pwm1_s;
   logic             pwm2_s;

   // Duty shadow: only updated at the period boundary so a period never
   // sees a mix of two duties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_r <= DUTY_OFFSET;
      end else if (cap) begin
         duty_r <= spd2duty(spd_t'(spd));
      end else begin
         duty_r <= duty_r;
      end
   end

   // Next-state decode. The low-side threshold is kept 12 bits wide so a
   // duty near full scale pushes it past the counter range instead of
   // wrapping back to small values, which would overlap the high side.
   always_comb begin
      pwm2_thr_s = {1'b0, duty_r} + {1'b0, NONOVERLAP};
      pwm1_s     = 1'b0;
      pwm2_s     = 1'b0;
      if (mtr_en) begin
         pwm1_s = (cnt >= NONOVERLAP) && (cnt < duty_r);
         pwm2_s = ({1'b0, cnt} >= pwm2_thr_s);
      end else begin
         pwm1_s = 1'b0;
         pwm2_s = 1'b0;
      end
   end

   // Output flops: glitch-free gate drive, one clock behind the decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PWM1 <= 1'b0;
         PWM2 <= 1'b0;
      end else begin
         PWM1 <= pwm1_s;
         PWM2 <= pwm2_s;
      end
   end

endmodule

// File: rtl/mtr_pwm_drv.sv
// -----------------------------------------------------------------------------
// mtr_pwm_drv
// Motor PWM driver: converts signed left/right speed commands into
// complementary, dead-time separated high/low-side PWM pairs for two
// H-bridges. Both channels share one phase-aligned 2048-clock period.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous reset, active-low
//   mtr_en    : low forces all four PWM outputs low (counter keeps running)
//   lft_spd   : signed left speed command, -1024..+1023
//   rght_spd  : signed right speed command, -1024..+1023
//   lftPWM1   : left high-side drive
//   lftPWM2   : left low-side drive
//   rghtPWM1  : right high-side drive
//   rghtPWM2  : right low-side drive
//   prd_strt  : one-clock pulse in the first cycle (cnt == 0) of each period
// -----------------------------------------------------------------------------
module mtr_pwm_drv
   import mtr_pkg::*;
#(
   parameter logic [PWM_W-1:0] NONOVERLAP = NONOVERLAP_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mtr_en,
   input  logic [PWM_W-1:0] lft_spd,
   input  logic [PWM_W-1:0] rght_spd,
   output logic             lftPWM1,
   output logic             lftPWM2,
   output logic             rghtPWM1,
   output logic             rghtPWM2,
   output logic             prd_strt
);

   logic [PWM_W-1:0] cnt_r;
   logic             cap_s;

   // Last cycle of the period: channels capture their new duty here.
   assign cap_s = (cnt_r == CNT_LAST);

   // Free-running period counter; natural 11-bit wrap 2047 -> 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + 11'd1;
      end
   end

   // Period-start strobe, registered from the capture cycle so it lines up
   // with cnt == 0 and stays quiet until the first wrap after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prd_strt <= 1'b0;
      end else begin
         prd_strt <= cap_s;
      end
   end

   pwm11_chan #(
      .NONOVERLAP (NONOVERLAP)
   ) u_lft_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .cnt    (cnt_r),
      .cap    (cap_s),
      .mtr_en (mtr_en),
      .spd    (lft_spd),
      .PWM1   (lftPWM1),
      .PWM2   (lftPWM2)
   );

   pwm11_chan #(
      .NONOVERLAP (NONOVERLAP)
   ) u_rght_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .cnt    (cnt_r),
      .cap    (cap_s),
      .mtr_en (mtr_en),
      .spd    (rght_spd),
      .PWM1   (rghtPWM1),
      .PWM2   (rghtPWM2)
   );

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// -----------------------------------------------------------------------------
// tb_mtr_pwm_drv
// Scoreboard bench: the stimulus process tracks the period counter and, at
// every period end, pushes the expected high times for the period just
// decoded. A negedge monitor accumulates the measured high times and pops /
// compares whenever the DUT raises prd_strt. Per-cycle checks cover
// non-overlap, enable gating and the prd_strt cadence.
// -----------------------------------------------------------------------------
module tb_mtr_pwm_drv;

   localparam int NO     = 32;
   localparam int PERIOD = 2048;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mtr_en = 1'b1;
   logic [10:0] lft_spd = 11'd0;
   logic [10:0] rght_spd = 11'd0;
   logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt;

   mtr_pwm_drv dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mtr_en   (mtr_en),
      .lft_spd  (lft_spd),
      .rght_spd (rght_spd),
      .lftPWM1  (lftPWM1),
      .lftPWM2  (lftPWM2),
      .rghtPWM1 (rghtPWM1),
      .rghtPWM2 (rghtPWM2),
      .prd_strt (prd_strt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit vld;
      int h1l, h2l, h1r, h2r;
   } exp_t;

   exp_t sb[$];

   int tests = 0;
   int fails = 0;

   // bench view of the DUT counter in the current cycle
   int tb_cnt  = 0;
   bit wrapped = 1'b0;
   int dl_m    = 1024;
   int dr_m    = 1024;
   bit en_first = 1'b1;
   bit en_mixed = 1'b0;

   // monitor state
   int acc_h1l = 0, acc_h2l = 0, acc_h1r = 0, acc_h2r = 0;
   int last_h1l = -1, last_h2l = -1, last_h1r = -1, last_h2r = -1;
   bit en_last = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int duty_of(input logic [10:0] s);
      return int'($signed(s)) + 1024;
   endfunction

   function automatic int h1_of(input int d, input bit en);
      if (!en || d <= NO) return 0;
      return d - NO;
   endfunction

   function automatic int h2_of(input int d, input bit en);
      int v;
      v = PERIOD - d - NO;
      if (!en || v < 0) return 0;
      return v;
   endfunction

   // One clock: account for the decode at this edge, push the expectation
   // at period end, capture the new duties, then advance.
   task automatic step();
      exp_t e;
      if (tb_cnt == 0) begin
         en_first = mtr_en;
         en_mixed = 1'b0;
      end else if (mtr_en != en_first) begin
         en_mixed = 1'b1;
      end
      if (tb_cnt == PERIOD - 1) begin
         e.vld = !en_mixed;
         e.h1l = h1_of(dl_m, en_first);
         e.h2l = h2_of(dl_m, en_first);
         e.h1r = h1_of(dr_m, en_first);
         e.h2r = h2_of(dr_m, en_first);
         sb.push_back(e);
         dl_m = duty_of(lft_spd);
         dr_m = duty_of(rght_spd);
      end
      @(posedge clk);
      #1;
      tb_cnt = (tb_cnt + 1) % PERIOD;
      if (tb_cnt == 0) wrapped = 1'b1;
   endtask

   task automatic goto(input int c);
      do begin
         step();
      end while (tb_cnt != c);
   endtask

   task automatic chk_last(input string tag, input int a, input int b, input int c, input int d);
      chk({tag, "_h1l"}, last_h1l, a);
      chk({tag, "_h2l"}, last_h2l, b);
      chk({tag, "_h1r"}, last_h1r, c);
      chk({tag, "_h2r"}, last_h2r, d);
   endtask

   // Monitor: per-cycle invariants plus period high-time scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         acc_h1l = 0; acc_h2l = 0; acc_h1r = 0; acc_h2r = 0;
         en_last = 1'b0;
      end else begin
         exp_t e;
         chk("ovl_l", int'(lftPWM1 & lftPWM2), 0);
         chk("ovl_r", int'(rghtPWM1 & rghtPWM2), 0);
         if (!en_last)
            chk("gate", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
         chk("prd_strt", int'(prd_strt), int'(tb_cnt == 0 && wrapped));
         acc_h1l += int'(lftPWM1);
         acc_h2l += int'(lftPWM2);
         acc_h1r += int'(rghtPWM1);
         acc_h2r += int'(rghtPWM2);
         if (prd_strt) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 0, 1);
            end else begin
               e = sb.pop_front();
               if (e.vld) begin
                  chk("per_h1l", acc_h1l, e.h1l);
                  chk("per_h2l", acc_h2l, e.h2l);
                  chk("per_h1r", acc_h1r, e.h1r);
                  chk("per_h2r", acc_h2r, e.h2r);
               end
            end
            last_h1l = acc_h1l; last_h2l = acc_h2l;
            last_h1r = acc_h1r; last_h2r = acc_h2r;
            acc_h1l = 0; acc_h2l = 0; acc_h1r = 0; acc_h2r = 0;
         end
         en_last = mtr_en;
      end
   end

   logic [10:0] edge_tbl [6];

   initial begin
      edge_tbl[0] = 11'h400;          // -1024 -> duty 0
      edge_tbl[1] = 11'h3FF;          // +1023 -> duty 2047
      edge_tbl[2] = -11'sd992;        // duty 32: high side never on
      edge_tbl[3] = -11'sd991;        // duty 33: high side one clock
      edge_tbl[4] = 11'd991;          // duty 2015: low side one clock
      edge_tbl[5] = 11'd992;          // duty 2016: low side never on

      // reset state
      #2;
      chk("rst_out", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt}), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tb_cnt = 0;

      // 50 % duty, dead-time edges
      goto(32);
      chk("l1_c31", int'(lftPWM1), 0);
      chk("r1_c31", int'(rghtPWM1), 0);
      goto(33);
      chk("l1_c32", int'(lftPWM1), 1);
      chk("r1_c32", int'(rghtPWM1), 1);
      goto(1024);
      chk("l1_c1023", int'(lftPWM1), 1);
      goto(1025);
      chk("l1_c1024", int'(lftPWM1), 0);
      goto(1056);
      chk("l2_c1055", int'(lftPWM2), 0);
      goto(1057);
      chk("l2_c1056", int'(lftPWM2), 1);
      goto(1);
      chk_last("p50", 992, 992, 992, 992);

      // full forward / full reverse
      lft_spd  = 11'h3FF;
      rght_spd = 11'h400;
      goto(1);
      chk_last("pre_full", 992, 992, 992, 992);
      goto(1);
      chk_last("full", 2015, 0, 0, 2016);

      // mid-period update
      lft_spd  = 11'd0;
      rght_spd = 11'd0;
      goto(1);
      goto(500);
      lft_spd = 11'h100;
      goto(1);
      chk_last("upd_cur", 992, 992, 992, 992);
      goto(1);
      chk_last("upd_next", 1248, 736, 992, 992);

      // capture-cycle edge
      goto(2047);
      rght_spd = 11'sd200;
      step();
      rght_spd = -11'sd200;
      goto(1);
      chk_last("cap_old", 1248, 736, 992, 992);
      goto(1);
      chk_last("cap_a", 1248, 736, 1192, 792);
      goto(1);
      chk_last("cap_b", 1248, 736, 792, 1192);

      // enable gating, resume mid-period with current decode
      lft_spd  = 11'd0;
      rght_spd = 11'd0;
      goto(1);
      goto(1000);
      mtr_en = 1'b0;
      repeat (100) step();
      mtr_en = 1'b1;
      step();
      chk("resume_l2", int'(lftPWM2), 1);
      chk("resume_l1", int'(lftPWM1), 0);
      goto(1);

      // reset pulse mid-period
      lft_spd = 11'h100;
      goto(1500);
      rst_n = 1'b0;
      #1;
      chk("rst_mid", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt}), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tb_cnt = 0; wrapped = 1'b0;
      dl_m = 1024; dr_m = 1024;
      goto(2);
      goto(1);
      chk_last("post_rst", 992, 992, 992, 992);
      goto(1);
      chk_last("post_rst2", 1248, 736, 992, 992);

      // random sweep
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0) lft_spd = edge_tbl[$urandom_range(0, 5)];
         else                           lft_spd = 11'($urandom_range(0, 2047));
         if ($urandom_range(0, 3) == 0) rght_spd = edge_tbl[$urandom_range(0, 5)];
         else                           rght_spd = 11'($urandom_range(0, 2047));
         repeat ($urandom_range(4, 24)) begin
            step();
            if (tb_cnt == 0) mtr_en = ($urandom_range(0, 3) != 0);
         end
      end
      mtr_en = 1'b1;
      goto(1);
      goto(1);
      chk("sb_drain", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
